// File: rtl/core_flit_serializer_if.sv
// Bundle of Core channel handshakes and the router FIFO write port seen by the serializer.
interface core_flit_serializer_if #(
    parameter int NCH    = 2,
    parameter int IN_W   = 32,
    parameter int FLIT_W = 10
);
    logic [NCH*IN_W-1:0] in_d;
    logic [NCH-1:0]      in_v;
    logic [NCH-1:0]      in_a;
    logic                is_full;
    logic [FLIT_W:0]     data_out;
    logic                wrreq;

    modport master (
        output in_d,
        output in_v,
        output is_full,
        input  in_a,
        input  data_out,
        input  wrreq
    );

    modport slave (
        input  in_d,
        input  in_v,
        input  is_full,
        output in_a,
        output data_out,
        output wrreq
    );
endinterface

// File: rtl/core_flit_serializer.sv
// Round-robin multi-channel word-to-flit serializer; same-route words from one channel
// share a single header, up to MAX_BURST words per header.
module core_flit_serializer #(
    parameter int NROUTE    = 5,
    parameter int NCODE     = 7,
    parameter int NDATA     = 20,
    parameter int FLIT_W    = 10,
    parameter int NCH       = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    core_flit_serializer_if.slave bus
);
    localparam int NWORD = NCODE + NDATA;
    localparam int NFLIT = (NWORD + FLIT_W - 1) / FLIT_W;
    localparam int IN_W  = NROUTE + NWORD;
    localparam int PAD_W = NFLIT * FLIT_W;
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int K_W   = (NFLIT > 1) ? $clog2(NFLIT) : 1;
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    localparam logic [K_W-1:0]  K_TOP     = K_W'(NFLIT - 1);
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NCH - 1);
    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DAT
    } state_t;

    state_t            state, state_nxt;
    logic [K_W-1:0]    k_r, k_nxt;
    logic [CH_W-1:0]   rr_ptr, rr_nxt;
    logic [BC_W-1:0]   burst_cnt, burst_nxt;
    logic [NROUTE-1:0] route_r, route_nxt;
    logic [NWORD-1:0]  word_r, word_nxt;
    logic [CH_W-1:0]   ch_r, ch_nxt;

    logic [NROUTE-1:0] ch_route [NCH];
    logic [NWORD-1:0]  ch_word  [NCH];

    logic              any_v;
    logic              merge_ok;
    logic              tail;
    logic              take;
    logic [CH_W-1:0]   take_ch;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   grant_next;
    logic [FLIT_W-1:0] hdr_body;
    logic [FLIT_W-1:0] dat_body;
    logic [PAD_W-1:0]  word_pad;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ch_word[i]  = bus.in_d[i*IN_W +: NWORD];
        assign ch_route[i] = bus.in_d[i*IN_W + NWORD +: NROUTE];
    end

    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
        logic [CH_W:0] sum;
        sum = {1'b0, base} + (CH_W+1)'(off);
        if (sum >= (CH_W+1)'(NCH)) sum = sum - (CH_W+1)'(NCH);
        return sum[CH_W-1:0];
    endfunction

    // Scan from the farthest offset down so the nearest valid channel after rr_ptr wins.
    always_comb begin
        grant = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            if (bus.in_v[wrap_idx(rr_ptr, off)]) grant = wrap_idx(rr_ptr, off);
        end
    end

    assign any_v      = |bus.in_v;
    assign grant_next = (grant == CH_LAST) ? '0 : grant + CH_W'(1);

    always_comb begin
        hdr_body = FLIT_W'(route_r);
        if (&route_r) hdr_body = FLIT_W'(1) << (FLIT_W - 1);
    end

    assign word_pad = PAD_W'(word_r);
    assign dat_body = word_pad[k_r*FLIT_W +: FLIT_W];

    assign merge_ok = bus.in_v[ch_r] && (ch_route[ch_r] == route_r) && (burst_cnt < BURST_MAX);
    assign tail     = (k_r == '0) && !merge_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            k_r       <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            route_r   <= '0;
            word_r    <= '0;
            ch_r      <= '0;
        end else begin
            state     <= state_nxt;
            k_r       <= k_nxt;
            rr_ptr    <= rr_nxt;
            burst_cnt <= burst_nxt;
            route_r   <= route_nxt;
            word_r    <= word_nxt;
            ch_r      <= ch_nxt;
        end
    end

    // Every word capture, whether a merge or a fresh grant, funnels through take/take_ch.
    always_comb begin
        state_nxt    = state;
        k_nxt        = k_r;
        rr_nxt       = rr_ptr;
        burst_nxt    = burst_cnt;
        route_nxt    = route_r;
        word_nxt     = word_r;
        ch_nxt       = ch_r;
        take         = 1'b0;
        take_ch      = grant;
        bus.in_a     = '0;
        bus.wrreq    = 1'b0;
        bus.data_out = '0;

        case (state)
            S_IDLE: begin
                if (any_v && !bus.is_full) begin
                    take      = 1'b1;
                    take_ch   = grant;
                    rr_nxt    = grant_next;
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                bus.data_out = {1'b0, hdr_body};
                bus.wrreq    = !bus.is_full;
                if (!bus.is_full) begin
                    burst_nxt = BC_W'(1);
                    k_nxt     = K_TOP;
                    state_nxt = S_DAT;
                end
            end
            S_DAT: begin
                bus.data_out = {tail, dat_body};
                bus.wrreq    = !bus.is_full;
                if (!bus.is_full) begin
                    if (k_r != '0) begin
                        k_nxt = k_r - K_W'(1);
                    end else if (merge_ok) begin
                        take      = 1'b1;
                        take_ch   = ch_r;
                        burst_nxt = burst_cnt + BC_W'(1);
                        k_nxt     = K_TOP;
                    end else if (any_v) begin
                        take      = 1'b1;
                        take_ch   = grant;
                        rr_nxt    = grant_next;
                        state_nxt = S_HDR;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (take) begin
            bus.in_a[take_ch] = 1'b1;
            route_nxt         = ch_route[take_ch];
            word_nxt          = ch_word[take_ch];
            ch_nxt            = take_ch;
        end
    end
endmodule

// File: tb/tb_core_flit_serializer.sv
// Directed and randomised bench for core_flit_serializer, checked against a
// queue-of-pending-flits reference model.
module tb_core_flit_serializer;
    localparam int NROUTE    = 5;
    localparam int NCODE     = 7;
    localparam int NDATA     = 20;
    localparam int FLIT_W    = 10;
    localparam int NCH       = 2;
    localparam int MAX_BURST = 2;
    localparam int NWORD     = NCODE + NDATA;
    localparam int NFLIT     = (NWORD + FLIT_W - 1) / FLIT_W;
    localparam int IN_W      = NROUTE + NWORD;

    localparam logic [FLIT_W:0] TAIL = {1'b1, {FLIT_W{1'b0}}};
    localparam logic [FLIT_W:0] SEQ_SINGLE [4] = '{11'h003, 11'h055, 11'h2AF, 11'h4DE};
    localparam logic [FLIT_W:0] SEQ_BURST [11] = '{11'h003, 11'h055, 11'h2AF, 11'h0DE,
                                                   11'h055, 11'h2AF, 11'h4DE,
                                                   11'h003, 11'h055, 11'h2AF, 11'h4DE};
    localparam logic [FLIT_W:0] RR_HDR [4] = '{11'h003, 11'h005, 11'h006, 11'h009};

    logic clk = 1'b0;
    logic reset;
    logic full_now;

    always #5 clk = ~clk;

    core_flit_serializer_if #(.NCH(NCH), .IN_W(IN_W), .FLIT_W(FLIT_W)) bus ();

    core_flit_serializer #(
        .NROUTE(NROUTE), .NCODE(NCODE), .NDATA(NDATA),
        .FLIT_W(FLIT_W), .NCH(NCH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int last_ack_cycle = 0;
    int last_tail_cycle = 0;
    int tail_cnt = 0;

    logic [IN_W-1:0]   src_q [NCH][$];
    logic [FLIT_W:0]   pend [$];
    int                m_rr = 0;
    int                m_burst = 0;
    int                m_ch = 0;
    logic [NROUTE-1:0] m_route = '0;

    logic [FLIT_W:0]   obs_data;
    logic              obs_wr;
    logic [NCH-1:0]    obs_ack;
    logic [FLIT_W:0]   wr_log [$];
    int                ack_log [$];

    function automatic logic [IN_W-1:0] mk(input logic [NROUTE-1:0] r, input logic [NCODE-1:0] c,
                                          input logic [NDATA-1:0] p);
        return {r, c, p};
    endfunction

    function automatic logic [NROUTE-1:0] route_of(input logic [IN_W-1:0] w);
        return w[IN_W-1 -: NROUTE];
    endfunction

    function automatic logic [FLIT_W:0] header_flit(input logic [NROUTE-1:0] r);
        logic [FLIT_W:0] h;
        h = '0;
        if (r == {NROUTE{1'b1}}) h[FLIT_W-1] = 1'b1;
        else h[NROUTE-1:0] = r;
        return h;
    endfunction

    function automatic logic [FLIT_W:0] data_flit(input logic [IN_W-1:0] w, input int k);
        logic [63:0] payload;
        logic [63:0] chunk;
        payload = 64'(w[NWORD-1:0]);
        chunk   = (payload >> (k * FLIT_W)) % (64'd1 << FLIT_W);
        return {1'b0, chunk[FLIT_W-1:0]};
    endfunction

    function automatic logic [NCH-1:0] cur_valid();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (src_q[i].size() != 0);
        return v;
    endfunction

    function automatic int rr_grant(input logic [NCH-1:0] v);
        for (int off = 0; off < NCH; off++) begin
            if (v[(m_rr + off) % NCH]) return (m_rr + off) % NCH;
        end
        return 0;
    endfunction

    task automatic push_data(input logic [IN_W-1:0] w);
        for (int k = NFLIT - 1; k >= 0; k--) pend.push_back(data_flit(w, k));
    endtask

    task automatic start_packet(input int g);
        logic [IN_W-1:0] w;
        w       = src_q[g].pop_front();
        m_ch    = g;
        m_route = route_of(w);
        m_burst = 1;
        m_rr    = (g + 1) % NCH;
        pend.push_back(header_flit(m_route));
        push_data(w);
    endtask

    // One clock of the reference: predicts this cycle's outputs and advances to the next.
    task automatic model_cycle(output logic [FLIT_W:0] e_data, output logic e_wr,
                               output logic [NCH-1:0] e_ack);
        logic [NCH-1:0] v;
        logic           merge;
        int             g;
        v      = cur_valid();
        g      = rr_grant(v);
        e_data = '0;
        e_wr   = 1'b0;
        e_ack  = '0;
        if (pend.size() == 0) begin
            if (v != '0 && !full_now) begin
                e_ack[g] = 1'b1;
                start_packet(g);
            end
        end else begin
            e_wr   = !full_now;
            e_data = pend[0];
            if (pend.size() == 1) begin
                merge = v[m_ch] && (route_of(src_q[m_ch][0]) == m_route) && (m_burst < MAX_BURST);
                if (!merge) e_data = e_data | TAIL;
                if (!full_now) begin
                    void'(pend.pop_front());
                    if (merge) begin
                        e_ack[m_ch] = 1'b1;
                        m_burst++;
                        push_data(src_q[m_ch].pop_front());
                    end else if (v != '0) begin
                        e_ack[g] = 1'b1;
                        start_packet(g);
                    end
                end
            end else if (!full_now) begin
                void'(pend.pop_front());
            end
        end
        if (reset == 1'b0) begin
            pend.delete();
            m_rr    = 0;
            m_burst = 0;
            m_ch    = 0;
            m_route = '0;
        end
    endtask

    task automatic applyStimulus();
        bus.in_v    = cur_valid();
        bus.is_full = full_now;
        for (int i = 0; i < NCH; i++)
            bus.in_d[i*IN_W +: IN_W] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input bit do_check);
        logic [FLIT_W:0] e_data;
        logic            e_wr;
        logic [NCH-1:0]  e_ack;
        applyStimulus();
        @(negedge clk);
        obs_data = bus.data_out;
        obs_wr   = bus.wrreq;
        obs_ack  = bus.in_a;
        model_cycle(e_data, e_wr, e_ack);
        if (do_check) begin
            checkOutput("data_out", 32'(obs_data), 32'(e_data));
            checkOutput("wrreq", 32'(obs_wr), 32'(e_wr));
            checkOutput("in_a", 32'(obs_ack), 32'(e_ack));
            if (obs_wr === 1'b1) begin
                wr_log.push_back(obs_data);
                if (obs_data[FLIT_W] === 1'b1) begin
                    tail_cnt++;
                    last_tail_cycle = cycle;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (obs_ack[i] === 1'b1) begin
                    ack_log.push_back(i);
                    last_ack_cycle = cycle;
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic bit any_src();
        return cur_valid() != '0;
    endfunction

    task automatic drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((pend.size() != 0 || any_src()) && n < max_cycles) begin
            step(1);
            n++;
        end
        checkOutput(tag, 32'(n < max_cycles), 32'd1);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        ack_log.delete();
        tail_cnt = 0;
    endtask

    task automatic random_phase(input int ncyc);
        logic [NROUTE-1:0] r;
        int                n;
        for (int c = 0; c < ncyc; c++) begin
            full_now = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NCH; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       r = 5'd3;
                        1:       r = 5'd5;
                        2:       r = 5'h1F;
                        default: r = NROUTE'($urandom);
                    endcase
                    n = int'($urandom_range(1, 3));
                    for (int j = 0; j < n; j++)
                        src_q[i].push_back(mk(r, NCODE'($urandom), NDATA'($urandom)));
                end
            end
            step(1);
        end
        full_now = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset    = 1'b0;
        full_now = 1'b0;
        step(0);
        step(1);
        reset = 1'b1;

        $display("[TB] single word");
        clear_logs();
        src_q[0].push_back(mk(5'd3, 7'h55, 20'hABCDE));
        drain("single_drain", 50);
        checkOutput("single_len", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput("single_flit", 32'(wr_log[i]), 32'(SEQ_SINGLE[i]));
        checkOutput("single_latency", 32'(last_tail_cycle - last_ack_cycle), 32'd4);

        $display("[TB] broadcast");
        clear_logs();
        src_q[0].push_back(mk(5'h1F, 7'h12, 20'h34567));
        drain("bcast_drain", 50);
        checkOutput("bcast_hdr", 32'(wr_log[0]), 32'h200);

        $display("[TB] merge");
        clear_logs();
        repeat (2) src_q[0].push_back(mk(5'd3, 7'h55, 20'hABCDE));
        drain("merge_drain", 50);
        checkOutput("merge_len", 32'(wr_log.size()), 32'd7);
        for (int i = 0; i < 7; i++) checkOutput("merge_flit", 32'(wr_log[i]), 32'(SEQ_BURST[i]));

        $display("[TB] burst limit");
        clear_logs();
        repeat (3) src_q[0].push_back(mk(5'd3, 7'h55, 20'hABCDE));
        drain("burst_drain", 50);
        checkOutput("burst_len", 32'(wr_log.size()), 32'd11);
        for (int i = 0; i < 11; i++) checkOutput("burst_flit", 32'(wr_log[i]), 32'(SEQ_BURST[i]));

        $display("[TB] stall");
        clear_logs();
        src_q[0].push_back(mk(5'd3, 7'h55, 20'hABCDE));
        repeat (3) step(1);
        full_now = 1'b1;
        repeat (3) begin
            step(1);
            checkOutput("stall_data", 32'(obs_data), 32'h2AF);
            checkOutput("stall_wrreq", 32'(obs_wr), 32'd0);
            checkOutput("stall_ack", 32'(obs_ack), 32'd0);
        end
        full_now = 1'b0;
        drain("stall_drain", 50);
        checkOutput("stall_len", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput("stall_flit", 32'(wr_log[i]), 32'(SEQ_SINGLE[i]));
        checkOutput("stall_latency", 32'(last_tail_cycle - last_ack_cycle), 32'd7);

        $display("[TB] reset mid-packet");
        clear_logs();
        src_q[0].push_back(mk(5'd3, 7'h55, 20'hABCDE));
        repeat (3) step(1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        checkOutput("rst_data", 32'(obs_data), 32'd0);
        checkOutput("rst_wrreq", 32'(obs_wr), 32'd0);
        checkOutput("rst_ack", 32'(obs_ack), 32'd0);

        $display("[TB] round robin");
        clear_logs();
        src_q[0].push_back(mk(5'd3, 7'h01, 20'h11111));
        src_q[0].push_back(mk(5'd6, 7'h02, 20'h22222));
        src_q[1].push_back(mk(5'd5, 7'h03, 20'h33333));
        src_q[1].push_back(mk(5'd9, 7'h04, 20'h44444));
        drain("rr_drain", 100);
        checkOutput("rr_ack_count", 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput("rr_ack_order", 32'(ack_log[i]), 32'(i % 2));
        for (int i = 0; i < 4; i++) checkOutput("rr_header", 32'(wr_log[4*i]), 32'(RR_HDR[i]));
        checkOutput("rr_tails", 32'(tail_cnt), 32'd4);

        $display("[TB] random traffic");
        random_phase(4000);
        drain("random_drain", 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_flit_serializer.md
# core_flit_serializer

Parametrised, multi-channel successor to the single-channel Core-to-router serializer. It arbitrates round-robin among NCH Core output channels and slices each word `[route | code | payload]` into one header flit plus NFLIT data flits. It also merges consecutive same-route words from the same channel under one header, up to MAX_BURST words. Each flit is `[tail | FLIT_W bits]`, written into the router input FIFO.

## Interface
- NROUTE, 5: route field width; must be ≤ FLIT_W.
- NCODE, 7: code field width.
- NDATA, 20: payload field width.
- FLIT_W, 10: flit body width. Derived: NWORD = NCODE+NDATA; NFLIT = ceil(NWORD/FLIT_W), which is 3 at defaults.
- NCH, 2: number of input channels, ≥1.
- MAX_BURST, 16: maximum words per header, ≥1.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- in_d  in  NCH*(NROUTE+NWORD)  channel i occupies slice i; layout per channel: `{route, code, payload}`.
- in_v  in  NCH  per-channel valid.
- in_a  out  NCH  per-channel ack; one-hot or zero.
- is_full  in  1  downstream FIFO full.
- data_out  out  FLIT_W+1  flit; bit FLIT_W is tail.
- wrreq  out  1  FIFO write strobe.

## Operation
- **Transfer rule:** a word transfers on a cycle where in_v[i] & in_a[i]. The producer holds in_d/in_v stable until ack; in_a is a single-cycle pulse. The word is captured into internal registers `route_r`, `word_r`, `ch_r` on transfer.
- **States:**
  - IDLE: no flit output.
  - HDR: emit header.
  - DAT(k), k = NFLIT-1..0: emit data flits, most significant chunk first.
- **Flit formats:**
  - Header = `{1'b0, zero-extended route_r}`.
  - If route_r is all ones (broadcast), header = `1 << (FLIT_W-1)`, with tail 0.
  - DAT(k) = `{tail, word_r[k*FLIT_W +: FLIT_W]}`. The top chunk is zero-extended; tail is 0 except on DAT(0) per the merge rule below.
- **Grant:** grant g is the lowest index at or cyclically after rr_ptr with in_v set. On each new-header grant, rr_ptr <= (g+1) mod NCH.
- **IDLE:**
  - If any in_v and !is_full: ack the grant, capture the word, go to HDR.
  - Otherwise stay in IDLE.
- **HDR:** if !is_full, set burst_cnt <= 1 and go to DAT(NFLIT-1).
- **DAT(k), k>0:** if !is_full, go to DAT(k-1).
- **DAT(0), when !is_full — merge decision:**
  - Merge when in_v[ch_r] is set, that channel's route equals route_r, and burst_cnt < MAX_BURST.
  - Merge: tail 0; ack ch_r and capture; burst_cnt++; go to DAT(NFLIT-1). rr_ptr is unchanged.
  - No merge: tail 1. If any in_v, ack the round-robin grant, capture, and go to HDR. Otherwise go to IDLE.
- **Stall:** in any emitting state with is_full, wrreq=0, in_a=0, and all state and registers hold. data_out keeps presenting the pending flit.
- **Emitting:** in HDR and DAT(k), wrreq = !is_full.
- **Outputs:** data_out, wrreq and in_a are combinational from state and registers. At IDLE, data_out=0.
- **Reset (reset low at a clock edge):**
  - state=IDLE, rr_ptr=0, burst_cnt=0, route_r=0, word_r=0, ch_r=0.
  - Hence wrreq=0, in_a=0, data_out=0.
  - Reset mid-packet abandons the packet with no tail. An already-acked word is dropped.
- **Burst accounting:** burst_cnt is $clog2(MAX_BURST+1) bits wide and never wraps; the merge check prevents exceeding MAX_BURST.

## Timing
- Ack at cycle T from IDLE: header written at T+1, data flits at T+2..T+1+NFLIT, assuming no stall.
- Merged words: NFLIT cycles per word, with the next ack in the same cycle as the previous DAT(0) write.
- New-route back-to-back: 1+NFLIT cycles per word, with no IDLE bubble.
- Each cycle with is_full adds exactly one cycle of latency. No flit is lost or duplicated.
- At most one in_a bit is high per cycle; in_a is never high in HDR or DAT(k>0).

## Test plan
- **Single word, defaults:** ch0, route 3, code 0x55, payload 0xABCDE -> ack at T; wrreq at T+1..T+4 with data_out 0x003, 0x055, 0x2AF, 0x4DE.
- **Broadcast and merge:** route 0x1F -> header 0x200. Two back-to-back ch0 words, both route 3 -> data_out sequence 0x003, 0x055, 0x2AF, 0x0DE, 0x055, 0x2AF, 0x4DE (one header, tail only on the last flit).
- **Burst limit:** MAX_BURST=2, three consecutive same-route words -> tail on word 2's last flit; a fresh 0x003 header precedes word 3.
- **Round-robin:** in_v=2'b11 continuously with differing routes -> grants alternate ch0, ch1, ch0; in_a one-hot; each packet carries its own header and tail.
- **Stall:** hold is_full high for 3 cycles during DAT(1) -> wrreq=0 and data_out constant at 0x2AF, no ack; the sequence resumes intact and total latency grows by 3.
- **Reset mid-packet:** reset low during DAT(1) -> next cycle wrreq=0, in_a=0, data_out=0, state IDLE. The next word after reset release starts with a header, and grant restarts from ch0.
